// File: rtl/frame_pkg.sv
// Shared frame-buffer definitions: default geometry, FSM states and the tagged pixel beat.
package frame_pkg;

    localparam int unsigned ROWS = 240;
    localparam int unsigned COLS = 320;
    localparam int unsigned DW   = 32;
    localparam int unsigned RW   = 8;
    localparam int unsigned CW   = 9;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    // One stream beat: pixel word plus its frame-position tags.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry synchronous FIFO of tagged pixels between the frame buffer and the stream port.
module pix_skid_fifo
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  pix_t       wdata,
    output pix_t       rdata,
    output logic [1:0] count,
    output logic       empty
);

    pix_t       mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    // Storage, pointers and occupancy; the caller never pushes when full or pops when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/frame_stream_reader.sv
// Drains one frame from the output frame buffer in raster order as a tagged valid/ready stream.
module frame_stream_reader #(
    parameter int unsigned ROWS = frame_pkg::ROWS,
    parameter int unsigned COLS = frame_pkg::COLS,
    parameter int unsigned DW   = frame_pkg::DW,
    parameter int unsigned RW   = frame_pkg::RW,
    parameter int unsigned CW   = frame_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          flip_h,
    output logic          mem_rd_en,
    output logic [RW-1:0] mem_row,
    output logic [CW-1:0] mem_col,
    input  logic [DW-1:0] mem_rd_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [DW-1:0] pix_data,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_eof,
    output logic          busy,
    output logic          done
);
    import frame_pkg::*;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          flip_q, flip_d;
    logic          done_q, done_d;
    logic          inflight_q;
    logic [2:0]    tag_q;        // {sof, eol, eof} of the read issued last cycle
    logic [2:0]    tag_d;
    logic          rd_issue;
    logic          pop;
    logic          last_col;
    logic          last_row;
    logic [2:0]    occupancy;    // beats buffered or in flight once this cycle's pop is done
    logic [1:0]    fifo_count;
    logic          fifo_empty;
    pix_t          push_pix;
    pix_t          head;

    assign pop       = !fifo_empty && pix_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign last_col  = (col_q == CW'(COLS - 1));
    assign last_row  = (row_q == RW'(ROWS - 1));
    // Tags follow the logical (unflipped) position.
    assign tag_d     = {(row_q == '0) && (col_q == '0), last_col, last_col && last_row};

    // Next-state, counter advance and read issue.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        flip_d   = flip_q;
        done_d   = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    flip_d  = flip_h;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            READ: begin
                // Issue only if the returning beat is guaranteed a FIFO slot.
                rd_issue = (occupancy < 3'd2);
                if (rd_issue) begin
                    if (last_col) begin
                        if (last_row) begin
                            // Counters hold so the address stays put while draining.
                            state_d = DRAIN;
                        end else begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && head.eof) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, in-flight tracking and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            flip_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            flip_q     <= flip_d;
            done_q     <= done_d;
            inflight_q <= rd_issue;
            if (rd_issue) begin
                tag_q <= tag_d;
            end
        end
    end

    assign push_pix = '{data: mem_rd_data, sof: tag_q[2], eol: tag_q[1], eof: tag_q[0]};

    pix_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .wdata (push_pix),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign mem_rd_en = rd_issue;
    assign mem_row   = row_q;
    assign mem_col   = flip_q ? (CW'(COLS - 1) - col_q) : col_q;
    assign pix_valid = !fifo_empty;
    assign pix_data  = head.data;
    assign pix_sof   = head.sof;
    assign pix_eol   = head.eol;
    assign pix_eof   = head.eof;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
